crc32_stream: RTL and testbench
===============================

Name: crc32_stream

Overview:
- Parametrised streaming CRC-32 engine: successor to the single-byte CRC-32 block. Processes DATA_BYTES bytes per clock.
- Frame boundaries come from explicit sop/eop markers, not a fixed payload length.
- Supports a partial last beat via byte keep. Outputs a registered FCS plus a residue check, so one block serves both TX FCS generation and RX FCS checking in the MAC.

Parameters:
- DATA_BYTES, 1, bytes per beat; legal 1, 2, 4, 8.
- POLY, global::crc_poly (32'h04C11DB7), normal-form polynomial; RTL uses its bit-reverse internally (LSB-first).
- INIT, 32'hFFFFFFFF, accumulator value at sop.
- XOROUT, 32'hFFFFFFFF, applied to the accumulator to form crc_out.
- RESIDUE, 32'hDEBB20E3, reflected-register value after a frame plus its correct FCS.
- CNT_W, 16, byte counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  beat qualifier; block is always ready, no back-pressure.
- in_sop  in  1  first beat of frame; valid only with in_valid.
- in_eop  in  1  last beat of frame; may coincide with in_sop.
- in_data  in  DATA_BYTES*8  in_data[7:0] is the first byte on the wire; each byte LSB-first.
- in_keep  in  DATA_BYTES  byte enables; all-ones except on an eop beat.
- crc_out  out  32  final FCS, byte 0 = crc_out[7:0] transmitted first.
- crc_valid  out  1  one-cycle pulse, result fields valid.
- crc_ok  out  1  accumulator == RESIDUE and no frame error; qualified by crc_valid.
- byte_count  out  CNT_W  bytes in the finished frame, saturating; qualified by crc_valid.
- err  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset (rst==0 at a clk edge) sets these outputs and state:
  - crc_out=0, crc_valid=0, crc_ok=0, byte_count=0, err=0
  - accumulator=INIT, state=IDLE, frame_bad=0
- Reset overrides all inputs; a reset mid-frame discards the frame with no crc_valid.
- States:
  - IDLE:
    - in_valid & in_sop: load INIT, fold the beat, clear the counter and frame_bad.
    - Go to DONE if in_eop, else ACTIVE.
    - in_valid without in_sop: beat dropped, err pulses.
  - ACTIVE:
    - in_valid folds the beat.
    - in_eop goes to DONE.
    - in_sop while ACTIVE: current frame abandoned (no crc_valid), err pulses, frame restarts from INIT with this beat.
  - DONE:
    - One cycle; crc_valid=1.
    - Same rules as IDLE apply to the incoming beat, so back-to-back frames run with zero idle cycles.
- Fold: bytes i=0..DATA_BYTES-1 in ascending order. Byte i is processed only when in_keep[i]=1.
- Keep rules:
  - Non-eop beats: in_keep treated as all-ones. Any zero sets frame_bad and err; the data is still folded.
  - Eop beat: in_keep must be thermometer from bit 0 (1, 11, 111...). Non-contiguous keep sets frame_bad and err, and only set bytes are folded.
  - keep==0 on eop is legal (zero bytes added).
- Latency: crc_out, crc_ok, byte_count registered and valid in the cycle after the eop beat. They hold until the next crc_valid.
- crc_out = accumulator ^ XOROUT. crc_ok = (accumulator == RESIDUE) & ~frame_bad.
- byte_count counts keep bits folded; it saturates at 2^CNT_W-1 and does not wrap.
- in_sop/in_eop/in_keep/in_data ignored when in_valid=0.
- Combinational path is DATA_BYTES byte steps chained; no multicycle paths.

Decomposition:
- Package global owns:
  - crc_len=32 and crc_poly.
  - New constants CRC32_INIT, CRC32_XOROUT, CRC32_RESIDUE.
  - Function reflect32 and typedef crc_state_e {IDLE, ACTIVE, DONE}.
- One sub-module: crc32_byte_step, purely combinational: crc_in[31:0], byte[7:0], reflected poly → crc_out. Instantiated DATA_BYTES times in a generate chain, with keep-gated bypass per lane.

Test Plan:
- DATA_BYTES=1, sop on '1', eop on '9', bytes 0x31..0x39 → crc_valid 1 cycle after eop, crc_out=32'hCBF43926, byte_count=9.
- DATA_BYTES=4, beats 32'h34333231, 32'h38373635, then 32'h00000039 with keep=4'b0001 → crc_out=32'hCBF43926, byte_count=9, err=0.
- DATA_BYTES=4, same 9 bytes followed by FCS bytes 26 39 F4 CB (13 bytes, last keep=4'b0001) → crc_ok=1. Flipping any data bit → crc_ok=0.
- Back-to-back: frame A eop, next cycle sop of frame B → two crc_valid pulses, each with the correct CRC. Single-beat sop&eop with keep=0 → crc_out=0, byte_count=0.
- Abort/protocol:
  - sop mid-frame → err pulse, only the second frame reports.
  - Beat without sop in IDLE → err, no state change.
  - Eop keep=4'b0101 → err, crc_ok=0.
- rst low for one cycle mid-frame → all outputs 0, no crc_valid. A following clean frame gives correct CRC.

Source files
------------

// File: rtl/crc32_stream_pkg.sv
// Shared CRC-32 constants, state encoding and bit-reversal helper for the
// streaming CRC engine.
package crc32_stream_pkg;

    localparam int          crc_len       = 32;
    localparam logic [31:0] crc_poly      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } crc_state_e;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_stream_if.sv
// Stream-in / result-out bundle of the CRC engine; slave side is the engine,
// master side is whoever feeds beats and consumes results.
interface crc32_stream_if #(
    parameter int DATA_BYTES = 1,
    parameter int CNT_W      = 16
);
    logic                    in_valid;
    logic                    in_sop;
    logic                    in_eop;
    logic [DATA_BYTES*8-1:0] in_data;
    logic [DATA_BYTES-1:0]   in_keep;

    logic [31:0]             crc_out;
    logic                    crc_valid;
    logic                    crc_ok;
    logic [CNT_W-1:0]        byte_count;
    logic                    err;

    modport master (
        output in_valid, in_sop, in_eop, in_data, in_keep,
        input  crc_out, crc_valid, crc_ok, byte_count, err
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_data, in_keep,
        output crc_out, crc_valid, crc_ok, byte_count, err
    );
endinterface

// File: rtl/crc32_stream_byte_step.sv
// One byte of LSB-first CRC-32 folding into a reflected register.
// Latency: purely combinational.
// Backpressure: none, no state.
module crc32_byte_step
    import crc32_stream_pkg::*;
(
    input  logic [crc_len-1:0] i_crc,
    input  logic [7:0]         i_byte,
    input  logic [crc_len-1:0] i_poly,
    output logic [crc_len-1:0] o_crc
);

    logic [crc_len-1:0] w_c;

    always_comb begin
        w_c = i_crc ^ {{(crc_len-8){1'b0}}, i_byte};
        for (int k = 0; k < 8; k++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ i_poly) : (w_c >> 1);
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 (DATA_BYTES per beat) with sop/eop framing, keep and residue check.
// Latency: crc_out/crc_ok/byte_count registered, crc_valid the cycle after eop.
// Backpressure: none; always ready, protocol violations flagged on err.
module crc32_stream
    import crc32_stream_pkg::*;
#(
    parameter int          DATA_BYTES = 1,
    parameter logic [31:0] POLY       = crc_poly,
    parameter logic [31:0] INIT       = CRC32_INIT,
    parameter logic [31:0] XOROUT     = CRC32_XOROUT,
    parameter logic [31:0] RESIDUE    = CRC32_RESIDUE,
    parameter int          CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    crc32_stream_if.slave  io_bus
);

    localparam logic [31:0] POLY_R = reflect32(POLY);

    crc_state_e            r_state;
    crc_state_e            w_state_nxt;
    logic [31:0]           r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_frame_bad;
    logic [31:0]           r_crc_out;
    logic                  r_crc_ok;
    logic [CNT_W-1:0]      r_byte_count;
    logic                  r_err;

    logic                  w_start;
    logic                  w_fold;
    logic                  w_proto_err;
    logic [DATA_BYTES-1:0] w_keep;
    logic [DATA_BYTES-1:0] w_keep_inc;
    logic                  w_keep_err;
    logic                  w_bad_nxt;
    logic [CNT_W:0]        w_sum;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [31:0]           w_acc_nxt;
    logic [31:0]           w_chain [0:DATA_BYTES];
    logic [31:0]           w_step  [0:DATA_BYTES-1];

    // Mid-frame beats are folded whole; eop keep must be a thermometer from lane 0.
    assign w_keep     = io_bus.in_eop ? io_bus.in_keep : '1;
    assign w_keep_inc = io_bus.in_keep + 1'b1;
    assign w_keep_err = io_bus.in_eop ? (|(io_bus.in_keep & w_keep_inc)) : ~(&io_bus.in_keep);

    assign w_chain[0] = w_start ? INIT : r_acc;

    for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
        crc32_byte_step u_step (
            .i_crc  (w_chain[g]),
            .i_byte (io_bus.in_data[g*8 +: 8]),
            .i_poly (POLY_R),
            .o_crc  (w_step[g])
        );
        assign w_chain[g+1] = w_keep[g] ? w_step[g] : w_chain[g];
    end

    assign w_acc_nxt = w_chain[DATA_BYTES];
    assign w_bad_nxt = (w_start ? 1'b0 : r_frame_bad) | w_keep_err;

    always_comb begin
        w_sum = {1'b0, (w_start ? {CNT_W{1'b0}} : r_cnt)};
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_sum = w_sum + (CNT_W+1)'(w_keep[i]);
        end
        w_cnt_nxt = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fold      = 1'b0;
        w_proto_err = 1'b0;
        case (r_state)
            ACTIVE: begin
                if (io_bus.in_valid) begin
                    w_fold = 1'b1;
                    if (io_bus.in_sop) begin
                        w_start     = 1'b1;
                        w_proto_err = 1'b1;
                    end
                    w_state_nxt = io_bus.in_eop ? DONE : ACTIVE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                if (io_bus.in_valid) begin
                    if (io_bus.in_sop) begin
                        w_start     = 1'b1;
                        w_fold      = 1'b1;
                        w_state_nxt = io_bus.in_eop ? DONE : ACTIVE;
                    end else begin
                        w_proto_err = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_acc        <= INIT;
            r_cnt        <= '0;
            r_frame_bad  <= 1'b0;
            r_crc_out    <= '0;
            r_crc_ok     <= 1'b0;
            r_byte_count <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_proto_err | (w_fold & w_keep_err);
            if (w_fold) begin
                r_acc       <= w_acc_nxt;
                r_cnt       <= w_cnt_nxt;
                r_frame_bad <= w_bad_nxt;
                if (io_bus.in_eop) begin
                    r_crc_out    <= w_acc_nxt ^ XOROUT;
                    r_crc_ok     <= (w_acc_nxt == RESIDUE) & ~w_bad_nxt;
                    r_byte_count <= w_cnt_nxt;
                end
            end
        end
    end

    assign io_bus.crc_out    = r_crc_out;
    assign io_bus.crc_valid  = (r_state == DONE);
    assign io_bus.crc_ok     = r_crc_ok;
    assign io_bus.byte_count = r_byte_count;
    assign io_bus.err        = r_err;

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream at 1 and 4 bytes per beat, results scoreboarded.
// Latency: expectations queued at eop, compared on each crc_valid pulse.
// Backpressure: none; err checked every driven cycle.
module tb_crc32_stream;

    typedef struct {
        logic [31:0] crc;
        logic        ok;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic exp_err1 = 1'b0;
    logic exp_err4 = 1'b0;
    exp_t sb1[$];
    exp_t sb4[$];
    exp_t e1, e4;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    crc32_stream_if #(.DATA_BYTES(1), .CNT_W(4))  b1();
    crc32_stream_if #(.DATA_BYTES(4), .CNT_W(16)) b4();

    crc32_stream #(.DATA_BYTES(1), .CNT_W(4))  u_dut1 (.clk(clk), .rst(rst), .io_bus(b1));
    crc32_stream #(.DATA_BYTES(4), .CNT_W(16)) u_dut4 (.clk(clk), .rst(rst), .io_bus(b4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_of(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic push_lit(input int which, input logic [31:0] crc, input logic ok, input int cnt);
        exp_t e;
        e.crc = crc;
        e.ok  = ok;
        e.cnt = cnt;
        if (which == 1) sb1.push_back(e);
        else            sb4.push_back(e);
    endtask

    task automatic push_model(input int which, input logic [7:0] b[$], input logic bad, input int cnt);
        logic [31:0] acc;
        acc = crc_of(b);
        push_lit(which, acc ^ 32'hFFFFFFFF, (acc == 32'hDEBB20E3) && !bad, cnt);
    endtask

    task automatic step1(input logic v, input logic s, input logic e, input logic [7:0] d, input logic ee);
        @(negedge clk);
        chk("err1", 32'(b1.err), 32'(exp_err1));
        b1.in_valid = v;
        b1.in_sop   = s;
        b1.in_eop   = e;
        b1.in_data  = d;
        b1.in_keep  = 1'b1;
        exp_err1    = ee;
    endtask

    task automatic step4(input logic v, input logic s, input logic e, input logic [31:0] d,
                         input logic [3:0] k, input logic ee);
        @(negedge clk);
        chk("err4", 32'(b4.err), 32'(exp_err4));
        b4.in_valid = v;
        b4.in_sop   = s;
        b4.in_eop   = e;
        b4.in_data  = d;
        b4.in_keep  = k;
        exp_err4    = ee;
    endtask

    task automatic idle4(input int n);
        for (int i = 0; i < n; i++) step4(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (b1.crc_valid === 1'b1) begin
            chk("valid1_expected", 32'(sb1.size() != 0), 32'd1);
            if (sb1.size() != 0) begin
                e1 = sb1.pop_front();
                chk("crc_out1", b1.crc_out, e1.crc);
                chk("crc_ok1", 32'(b1.crc_ok), 32'(e1.ok));
                chk("byte_count1", 32'(b1.byte_count), 32'(e1.cnt));
            end
        end
    end

    always @(negedge clk) begin
        if (b4.crc_valid === 1'b1) begin
            chk("valid4_expected", 32'(sb4.size() != 0), 32'd1);
            if (sb4.size() != 0) begin
                e4 = sb4.pop_front();
                chk("crc_out4", b4.crc_out, e4.crc);
                chk("crc_ok4", 32'(b4.crc_ok), 32'(e4.ok));
                chk("byte_count4", 32'(b4.byte_count), 32'(e4.cnt));
            end
        end
    end

    initial begin
        b1.in_valid = 1'b0; b1.in_sop = 1'b0; b1.in_eop = 1'b0; b1.in_data = '0; b1.in_keep = '0;
        b4.in_valid = 1'b0; b4.in_sop = 1'b0; b4.in_eop = 1'b0; b4.in_data = '0; b4.in_keep = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_crc_out4", b4.crc_out, 32'h0);
        chk("rst_crc_valid4", 32'(b4.crc_valid), 32'd0);
        chk("rst_crc_ok4", 32'(b4.crc_ok), 32'd0);
        chk("rst_byte_count4", 32'(b4.byte_count), 32'd0);
        chk("rst_err4", 32'(b4.err), 32'd0);
        chk("rst_crc_valid1", 32'(b1.crc_valid), 32'd0);
        rst = 1'b1;

        // 1 byte/beat: check value, then a non-sop beat straight out of DONE
        push_lit(1, 32'hCBF43926, 1'b0, 9);
        for (int i = 0; i < 9; i++) step1(1'b1, i == 0, i == 8, 8'h31 + 8'(i), 1'b0);
        step1(1'b1, 1'b0, 1'b0, 8'hAA, 1'b1);
        step1(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        // 20 bytes into a 4-bit counter: saturates at 15
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'(i * 13 + 5));
        push_model(1, q, 1'b0, 15);
        for (int i = 0; i < 20; i++) step1(1'b1, i == 0, i == 19, q[i], 1'b0);
        repeat (3) step1(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 4 bytes/beat: "123456789" with partial last beat
        push_lit(4, 32'hCBF43926, 1'b0, 9);
        step4(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b1, 32'h00000039, 4'h1, 1'b0);
        idle4(2);

        // Frame plus its FCS lands on the residue
        push_lit(4, 32'h2144DF1C, 1'b1, 13);
        step4(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b0, 32'hF4392639, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b1, 32'h000000CB, 4'h1, 1'b0);
        idle4(2);

        // Same with one data bit flipped
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        q[0] = 8'h30;
        push_model(4, q, 1'b0, 13);
        step4(1'b1, 1'b1, 1'b0, 32'h34333230, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b0, 32'hF4392639, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b1, 32'h000000CB, 4'h1, 1'b0);
        idle4(2);

        // Back-to-back frames with no idle gap, then an empty frame
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'h61 + 8'(i));
        push_model(4, q, 1'b0, 4);
        step4(1'b1, 1'b1, 1'b1, 32'h64636261, 4'hF, 1'b0);
        q.delete();
        for (int i = 0; i < 7; i++) q.push_back(8'h65 + 8'(i));
        push_model(4, q, 1'b0, 7);
        step4(1'b1, 1'b1, 1'b0, 32'h68676665, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b1, 32'h006B6A69, 4'h7, 1'b0);
        push_lit(4, 32'h00000000, 1'b0, 0);
        step4(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0);
        idle4(2);

        // sop mid-frame abandons the first frame
        step4(1'b1, 1'b1, 1'b0, 32'h11223344, 4'hF, 1'b0);
        push_lit(4, 32'hCBF43926, 1'b0, 9);
        step4(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF, 1'b1);
        step4(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b1, 32'h00000039, 4'h1, 1'b0);
        idle4(2);

        // Beats without sop while idle are dropped
        step4(1'b1, 1'b0, 1'b0, 32'h55555555, 4'hF, 1'b1);
        step4(1'b1, 1'b0, 1'b1, 32'h66666666, 4'hF, 1'b1);
        idle4(2);

        // Non-contiguous eop keep: only set lanes folded, frame bad
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'h31 + 8'(i));
        q.push_back(8'h37); q.push_back(8'h39);
        push_model(4, q, 1'b1, 6);
        step4(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b1, 32'h00390037, 4'h5, 1'b1);
        idle4(2);

        // Hole in a mid-frame keep: data still folded, crc_ok suppressed
        push_lit(4, 32'h2144DF1C, 1'b0, 13);
        step4(1'b1, 1'b1, 1'b0, 32'h34333231, 4'h7, 1'b1);
        step4(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b0, 32'hF4392639, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b1, 32'h000000CB, 4'h1, 1'b0);
        idle4(2);

        // Reset mid-frame, then a clean frame
        step4(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF, 1'b0);
        @(negedge clk);
        chk("err4", 32'(b4.err), 32'(exp_err4));
        rst = 1'b0;
        b4.in_valid = 1'b0;
        exp_err4 = 1'b0;
        @(negedge clk);
        chk("midrst_crc_out4", b4.crc_out, 32'h0);
        chk("midrst_crc_valid4", 32'(b4.crc_valid), 32'd0);
        chk("midrst_crc_ok4", 32'(b4.crc_ok), 32'd0);
        chk("midrst_byte_count4", 32'(b4.byte_count), 32'd0);
        chk("midrst_err4", 32'(b4.err), 32'd0);
        rst = 1'b1;
        push_lit(4, 32'hCBF43926, 1'b0, 9);
        step4(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF, 1'b0);
        step4(1'b1, 1'b0, 1'b1, 32'h00000039, 4'h1, 1'b0);
        idle4(3);

        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("sb4_drained", 32'(sb4.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
